bitmap_column_reader: RTL

Read-side engine for the bitmap dual-port memory. The USB side writes 16-bit words into the memory; this block walks the 256-bit application port one column word at a time, starting at a programmed base address, and hands each column to the print/column-advance logic over a valid/ready handshake. It sits between the bitmap memory port B (`addrb`/`dob`) and the column consumer.

---
 rtl/bitmap_pkg.sv | 16 +
 rtl/bitmap_column_reader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/bitmap_pkg.sv
// Shared constants for the bitmap dual-port memory and its column reader.
// The memory wrapper and the reader both take their widths from here.
package bitmap_pkg;

  localparam int BMP_ADDR_W   = 12;
  localparam int BMP_WORD_W   = 256;
  localparam int BMP_MAX_COLS = 4096;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_WAIT,
    RD_PRESENT
  } rd_state_e;

endpackage

// File: rtl/bitmap_column_reader.sv
// Walks the bitmap memory port B one column word at a time from a base address
// and presents each word to the column consumer over a valid/ready handshake.
module bitmap_column_reader
  import bitmap_pkg::*;
#(
  parameter int ADDR_W = BMP_ADDR_W,
  parameter int DATA_W = BMP_WORD_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_cols,
  input  logic              abort,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dob,
  output logic [DATA_W-1:0] col_data,
  output logic              col_valid,
  input  logic              col_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   col_idx
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  localparam logic [ADDR_W:0]   MAX_COLS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_COL  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0]  LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT);

  function automatic logic [ADDR_W:0] clamp_cols(input logic [ADDR_W:0] n);
    return (n > MAX_COLS) ? MAX_COLS : n;
  endfunction

  rd_state_e         state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remain;
  logic [LAT_W-1:0]  lat_cnt;
  logic [ADDR_W:0]   start_cols;
  logic [ADDR_W-1:0] ptr_next;

  always_comb begin
    start_cols = clamp_cols(num_cols);
    ptr_next   = ptr + ONE_ADDR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RD_IDLE;
      ptr       <= '0;
      remain    <= '0;
      lat_cnt   <= '0;
      addrb     <= '0;
      col_data  <= '0;
      col_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      col_idx   <= '0;
    end else begin
      done <= 1'b0;
      // abort outranks everything once a swatch is running; in IDLE it is a no-op
      if (abort && (state != RD_IDLE)) begin
        state     <= RD_IDLE;
        col_valid <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
      end else begin
        case (state)
          RD_IDLE: begin
            if (start) begin
              ptr     <= base_addr;
              remain  <= start_cols;
              col_idx <= '0;
              if (start_cols == '0) begin
                done <= 1'b1;
              end else begin
                addrb <= base_addr;
                busy  <= 1'b1;
                state <= RD_FETCH;
              end
            end
          end
          RD_FETCH: begin
            lat_cnt <= LAT_ONE;
            state   <= RD_WAIT;
          end
          RD_WAIT: begin
            if (lat_cnt == LAT_LAST) begin
              col_data  <= dob;
              col_valid <= 1'b1;
              state     <= RD_PRESENT;
            end else begin
              lat_cnt <= lat_cnt + LAT_ONE;
            end
          end
          RD_PRESENT: begin
            if (col_valid && col_ready) begin
              col_valid <= 1'b0;
              col_idx   <= col_idx + ONE_COL;
              remain    <= remain - ONE_COL;
              ptr       <= ptr_next;
              if (remain == ONE_COL) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= RD_IDLE;
              end else begin
                // addrb is left alone after the last column so it holds in IDLE
                addrb <= ptr_next;
                state <= RD_FETCH;
              end
            end
          end
          default: state <= RD_IDLE;
        endcase
      end
    end
  end

endmodule
